pc_stack: RTL and testbench
===========================

PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n_i  input  1  reset, synchronous, active-low.
REQ-003 en_i  input  1  fetch-advance strobe; PC and stack update only when 1.
REQ-004 Npc_i  input  12  next PC from the next-PC stage.
REQ-005 push_i  input  1  JSB executing: push return address PC_o+1.
REQ-006 int_i  input  1  interrupt entry: push Npc_i, the address resumed on return.
REQ-007 pop_i  input  1  RET/RETI executing: pop top entry.
REQ-008 PC_o  output  12  current program counter, registered.
REQ-009 stackaddr_o  output  12  top-of-stack entry, driven to the next-PC stage's stack address input.
REQ-010 full_o  output  1  stack holds 8 entries.
REQ-011 empty_o  output  1  stack holds 0 entries.
REQ-012 overflow_o  output  1  sticky: push attempted while full.
REQ-013 underflow_o  output  1  sticky: pop attempted while empty.

Function
REQ-014 With en_i=1, PC_o SHALL load Npc_i at the clock edge; with en_i=0, PC_o, stack contents, count and flags SHALL hold.
REQ-015 The stack SHALL be an 8-entry LIFO of 12-bit addresses with a 4-bit count (0..8).
REQ-016 stackaddr_o SHALL be combinational from registered state: the entry at count-1, or 12'h000 when empty; no added latency.
REQ-017 Push value: int_i=1 -> Npc_i; else push_i=1 -> PC_o+1, 12-bit modulo (12'hFFF+1 = 12'h000).
REQ-018 int_i SHALL take priority over push_i; when both are 1, exactly one entry (Npc_i) is pushed.
REQ-019 Push when not full: write at index count, count+1.
REQ-020 Push when full: contents and count unchanged, overflow_o set.
REQ-021 Pop when not empty: count-1; popped entry is not cleared.
REQ-022 Pop when empty: count stays 0, underflow_o set.
REQ-023 Push (push_i or int_i) and pop in the same enabled cycle, not empty: the top entry SHALL be overwritten with the push value, count unchanged; no flag set, including when full.
REQ-024 Push and pop in the same enabled cycle, empty: treated as a push (count 0->1); underflow_o set.
REQ-025 full_o = (count==8); empty_o = (count==0); both combinational from count.
REQ-026 overflow_o and underflow_o SHALL remain set until reset.

Reset
REQ-027 While rst_n_i=0 at a clock edge: PC_o=12'h000, count=0, overflow_o=0, underflow_o=0; en_i and all other inputs are ignored.
REQ-028 After reset: empty_o=1, full_o=0, stackaddr_o=12'h000; stack array contents need not be reset.
REQ-029 Reset asserted mid-sequence SHALL discard all pending stack state in that same cycle.

Structure
REQ-030 ADDR_W=12, STACK_DEPTH=8 and the count width SHALL be defined in the shared gumnut_pkg.
REQ-031 The LIFO storage and count logic SHALL be a single sub-module, pc_lifo; PC register and push-value selection stay in pc_stack.

Verification
REQ-032 Reset, then en_i=1 with Npc_i=12'h001,12'h002 -> PC_o=12'h001 then 12'h002; empty_o=1, stackaddr_o=12'h000.
REQ-033 PC_o=12'h010, push_i=1 for one cycle -> stackaddr_o=12'h011, count 1; next cycle pop_i=1 -> empty_o=1, stackaddr_o=12'h000.
REQ-034 Push 8 times from PC_o=12'h100..12'h107 -> full_o=1, stackaddr_o=12'h108; 9th push -> overflow_o=1, stackaddr_o still 12'h108.
REQ-035 Empty stack, pop_i=1 -> underflow_o=1, count 0; pop_i and push_i together at PC_o=12'h020 -> count 1, stackaddr_o=12'h021, underflow_o=1.
REQ-036 Push_i, int_i and pop_i together with Npc_i=12'h3C0 on a stack with top 12'h055 -> top becomes 12'h3C0, count unchanged; repeated with en_i=0 -> no change.
REQ-037 PC_o=12'hFFF, push_i=1 -> stackaddr_o=12'h000, count 1; then rst_n_i=0 for one edge -> empty_o=1, PC_o=12'h000, flags 0.

Source files
------------

// File: rtl/gumnut_pkg.sv
// Shared widths, types and the stack-operation decode used by the PC stack slice.
package gumnut_pkg;

  localparam int unsigned ADDR_W      = 12;
  localparam int unsigned STACK_DEPTH = 8;
  localparam int unsigned CNT_W       = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W       = $clog2(STACK_DEPTH);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [IDX_W-1:0]  idx_t;

  typedef enum logic [1:0] {
    OpIdle,
    OpPush,
    OpPop,
    OpReplace
  } stack_op_e;

  // A push together with a pop collapses into a single top-of-stack replace.
  function automatic stack_op_e decode_op(logic en, logic push, logic pop);
    if (!en)              return OpIdle;
    else if (push && pop) return OpReplace;
    else if (push)        return OpPush;
    else if (pop)         return OpPop;
    else                  return OpIdle;
  endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Fetch-side bundle between the next-PC stage and the PC/return-stack block.
interface pc_stack_if;
  import gumnut_pkg::*;

  logic  en_i;
  addr_t Npc_i;
  logic  push_i;
  logic  int_i;
  logic  pop_i;
  addr_t PC_o;
  addr_t stackaddr_o;
  logic  full_o;
  logic  empty_o;
  logic  overflow_o;
  logic  underflow_o;

  modport master (
    output en_i, Npc_i, push_i, int_i, pop_i,
    input  PC_o, stackaddr_o, full_o, empty_o, overflow_o, underflow_o
  );

  modport slave (
    input  en_i, Npc_i, push_i, int_i, pop_i,
    output PC_o, stackaddr_o, full_o, empty_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/pc_lifo.sv
// 8-entry return-address LIFO with count, full/empty status and sticky error flags.
module pc_lifo
  import gumnut_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  logic  en_i,
  input  logic  push_i,
  input  logic  pop_i,
  input  addr_t push_data_i,
  output addr_t top_o,
  output logic  full_o,
  output logic  empty_o,
  output logic  overflow_o,
  output logic  underflow_o
);

  addr_t     mem_q [STACK_DEPTH];
  cnt_t      count_q, count_d;
  logic      ov_q, ov_d;
  logic      un_q, un_d;
  logic      wr_en;
  idx_t      wr_idx;
  idx_t      top_idx;
  stack_op_e op;

  assign op      = decode_op(en_i, push_i, pop_i);
  assign top_idx = IDX_W'(count_q - CNT_W'(1));
  assign full_o  = (count_q == CNT_W'(STACK_DEPTH));
  assign empty_o = (count_q == '0);

  always_comb begin
    count_d = count_q;
    ov_d    = ov_q;
    un_d    = un_q;
    wr_en   = 1'b0;
    wr_idx  = IDX_W'(count_q);
    unique case (op)
      OpPush: begin
        if (full_o) begin
          ov_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
      end
      OpPop: begin
        if (empty_o) un_d = 1'b1;
        else         count_d = count_q - CNT_W'(1);
      end
      OpReplace: begin
        wr_en = 1'b1;
        if (empty_o) begin
          // Nothing to pop: behaves as a plain push but still records the underflow.
          count_d = CNT_W'(1);
          un_d    = 1'b1;
        end else begin
          wr_idx = top_idx;
        end
      end
      OpIdle: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
      ov_q    <= 1'b0;
      un_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      ov_q    <= ov_d;
      un_q    <= un_d;
    end
  end

  // Storage is never reset; entries above the count are simply stale.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && wr_en) mem_q[wr_idx] <= push_data_i;
  end

  assign top_o       = empty_o ? '0 : mem_q[top_idx];
  assign overflow_o  = ov_q;
  assign underflow_o = un_q;

endmodule

// File: rtl/pc_stack.sv
// Program counter register plus return-address stack feeding the next-PC stage.
module pc_stack
  import gumnut_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  pc_stack_if.slave bus
);

  addr_t pc_q, pc_d;
  addr_t push_val;
  logic  push_req;

  // Interrupt entry wins over JSB: resume address is the incoming next PC.
  assign push_req = bus.push_i | bus.int_i;
  assign push_val = bus.int_i ? bus.Npc_i : pc_q + ADDR_W'(1);

  always_comb begin
    pc_d = pc_q;
    if (bus.en_i) pc_d = bus.Npc_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) pc_q <= '0;
    else          pc_q <= pc_d;
  end

  pc_lifo u_lifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .en_i        (bus.en_i),
    .push_i      (push_req),
    .pop_i       (bus.pop_i),
    .push_data_i (push_val),
    .top_o       (bus.stackaddr_o),
    .full_o      (bus.full_o),
    .empty_o     (bus.empty_o),
    .overflow_o  (bus.overflow_o),
    .underflow_o (bus.underflow_o)
  );

  assign bus.PC_o = pc_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed vector table plus randomized run against a queue-based return-stack model.
module tb_pc_stack;

  typedef struct {
    logic        rst_n, en, push, intr, pop;
    logic [11:0] npc;
    logic [11:0] pc, top;
    logic        full, empty, ov, un;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  pc_stack_if bus ();

  pc_stack dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a bounded queue of return addresses.
  logic [11:0] m_pc;
  logic [11:0] m_q[$];
  logic        m_ov, m_un;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_n_v, en, push, intr, pop,
                              input logic [11:0] npc, pc, top,
                              input logic full, empty, ov, un);
    vec_t v;
    v.rst_n = rst_n_v; v.en = en; v.push = push; v.intr = intr; v.pop = pop;
    v.npc = npc; v.pc = pc; v.top = top;
    v.full = full; v.empty = empty; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, e, p, i, o, input logic [11:0] n);
    rst_n      = r;
    bus.en_i   = e;
    bus.push_i = p;
    bus.int_i  = i;
    bus.pop_i  = o;
    bus.Npc_i  = n;
  endtask

  task automatic check_all(input string tag, input logic [11:0] pc, top,
                           input logic full, empty, ov, un);
    check({tag, " pc"},    bus.PC_o,        pc);
    check({tag, " top"},   bus.stackaddr_o, top);
    check({tag, " full"},  {11'd0, bus.full_o},      {11'd0, full});
    check({tag, " empty"}, {11'd0, bus.empty_o},     {11'd0, empty});
    check({tag, " ovf"},   {11'd0, bus.overflow_o},  {11'd0, ov});
    check({tag, " unf"},   {11'd0, bus.underflow_o}, {11'd0, un});
  endtask

  task automatic model_step(input logic r, e, p, i, o, input logic [11:0] n);
    logic [11:0] val;
    if (!r) begin
      m_pc = '0;
      m_q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else if (e) begin
      val = i ? n : m_pc + 12'd1;
      if ((p || i) && o) begin
        if (m_q.size() == 0) begin
          m_q.push_back(val);
          m_un = 1'b1;
        end else begin
          m_q[m_q.size() - 1] = val;
        end
      end else if (p || i) begin
        if (m_q.size() == 8) m_ov = 1'b1;
        else                 m_q.push_back(val);
      end else if (o) begin
        if (m_q.size() == 0) m_un = 1'b1;
        else                 void'(m_q.pop_back());
      end
      m_pc = n;
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

    // Directed table: basic fetch, push/pop, fill to full, overflow, underflow, replace, wrap.
    vecs.push_back(mk(0,1,1,0,0,12'h123, 12'h000,12'h000,0,1,0,0));
    vecs.push_back(mk(1,1,0,0,0,12'h001, 12'h001,12'h000,0,1,0,0));
    vecs.push_back(mk(1,1,0,0,0,12'h002, 12'h002,12'h000,0,1,0,0));
    vecs.push_back(mk(1,1,0,0,0,12'h010, 12'h010,12'h000,0,1,0,0));
    vecs.push_back(mk(1,1,1,0,0,12'h011, 12'h011,12'h011,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,1,12'h012, 12'h012,12'h000,0,1,0,0));
    vecs.push_back(mk(1,1,0,0,0,12'h100, 12'h100,12'h000,0,1,0,0));
    for (int k = 0; k < 8; k++) begin
      vecs.push_back(mk(1,1,1,0,0,12'h101 + 12'(k), 12'h101 + 12'(k), 12'h101 + 12'(k),
                        (k == 7), 0, 0, 0));
    end
    vecs.push_back(mk(1,1,1,0,0,12'h109, 12'h109,12'h108,1,0,1,0));
    vecs.push_back(mk(1,1,1,0,1,12'h200, 12'h200,12'h10A,1,0,1,0));
    vecs.push_back(mk(0,1,0,0,1,12'h555, 12'h000,12'h000,0,1,0,0));
    vecs.push_back(mk(1,1,0,0,1,12'h020, 12'h020,12'h000,0,1,0,1));
    vecs.push_back(mk(1,1,1,0,1,12'h021, 12'h021,12'h021,0,0,0,1));
    vecs.push_back(mk(1,1,0,1,0,12'h055, 12'h055,12'h055,0,0,0,1));
    vecs.push_back(mk(1,1,1,1,1,12'h3C0, 12'h3C0,12'h3C0,0,0,0,1));
    vecs.push_back(mk(1,0,1,1,1,12'h777, 12'h3C0,12'h3C0,0,0,0,1));
    vecs.push_back(mk(1,1,0,0,1,12'h3C1, 12'h3C1,12'h021,0,0,0,1));
    vecs.push_back(mk(1,1,0,0,1,12'h3C2, 12'h3C2,12'h000,0,1,0,1));
    vecs.push_back(mk(0,1,1,0,0,12'h000, 12'h000,12'h000,0,1,0,0));
    vecs.push_back(mk(1,1,0,0,0,12'hFFF, 12'hFFF,12'h000,0,1,0,0));
    vecs.push_back(mk(1,1,1,0,0,12'h000, 12'h000,12'h000,0,0,0,0));
    vecs.push_back(mk(0,1,1,1,1,12'hABC, 12'h000,12'h000,0,1,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].push, vecs[i].intr, vecs[i].pop, vecs[i].npc);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].top,
                vecs[i].full, vecs[i].empty, vecs[i].ov, vecs[i].un);
    end

    // Randomized run; alternating push-heavy and pop-heavy phases reach both ends.
    for (int i = 0; i < 400; i++) begin
      logic        r, e, p, it, o;
      logic [11:0] n;
      int          phase;
      phase = (i / 40) % 2;
      r  = (i == 0) ? 1'b0 : ($urandom_range(63) != 0);
      e  = ($urandom_range(7) != 0);
      p  = ($urandom_range(99) < ((phase != 0) ? 20 : 65));
      it = ($urandom_range(9) == 0);
      o  = ($urandom_range(99) < ((phase != 0) ? 65 : 15));
      n  = 12'($urandom);
      drive(r, e, p, it, o, n);
      model_step(r, e, p, it, o, n);
      @(posedge clk);
      #1;
      check_all($sformatf("rnd%0d", i), m_pc,
                (m_q.size() == 0) ? 12'h000 : m_q[m_q.size() - 1],
                (m_q.size() == 8), (m_q.size() == 0), m_ov, m_un);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
